// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces whole-scan results,
// rejects multi-key presses and emits single-cycle key events plus a pop-mode flag.
module keypad_scanner #(
  parameter int         CLK_HZ         = 100_000_000,
  parameter int         SCAN_HZ        = 1000,
  parameter int         DEBOUNCE_SCANS = 4,
  parameter logic [3:0] POP_KEY        = 4'hE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       pop_clear,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       pop
);
  localparam int            DWELL  = CLK_HZ / SCAN_HZ;
  localparam int            DW     = $clog2(DWELL);
  localparam logic [DW-1:0] LAST   = DW'(DWELL - 1);
  localparam logic [DW-1:0] PRE    = DW'(DWELL - 2);
  localparam logic [3:0]    DEB    = 4'(DEBOUNCE_SCANS);
  localparam logic [63:0]   KEYMAP = 64'hDEF0_C987_B654_A321;

  typedef enum logic {S_DRIVE, S_SAMPLE} state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_dwell;
  logic [1:0]      r_col_idx;
  logic [3:0]      r_row_s1, r_row_s2;
  logic [2:0][3:0] r_hits;
  logic [4:0]      r_cand, r_stable, w_res;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [15:0]     w_hits;
  logic [4:0]      w_nhits;
  logic [3:0]      w_idx;
  logic            w_sample, w_scan_end, w_accept, w_event, w_toggle;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_DRIVE;
      r_dwell   <= '0;
      r_col_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dwell   <= (r_dwell == LAST) ? '0 : r_dwell + 1'b1;
      r_col_idx <= w_sample ? r_col_idx + 1'b1 : r_col_idx;
    end
  end

  always_comb begin
    w_state_nxt = (r_state == S_DRIVE && r_dwell == PRE) ? S_SAMPLE : S_DRIVE;
    w_sample    = r_state == S_SAMPLE;
    w_scan_end  = w_sample && r_col_idx == 2'd3;
  end

  assign col = ~(4'b0001 << r_col_idx);

  // Column 3 is evaluated live in its sample cycle so the event lands one cycle later
  always_comb begin
    w_hits  = '0;
    w_nhits = '0;
    w_idx   = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) w_hits[r*4+c] = r_hits[c][r];
      w_hits[r*4+3] = ~r_row_s2[r];
    end
    for (int i = 0; i < 16; i++) begin
      if (w_hits[i]) begin
        w_nhits = w_nhits + 5'd1;
        w_idx   = 4'(i);
      end
    end
  end

  assign w_res     = (w_nhits == 5'd1) ? {1'b1, KEYMAP[{w_idx, 2'b00} +: 4]} : 5'd0;
  assign w_cnt_nxt = (w_res == r_cand) ? ((r_cnt == DEB) ? r_cnt : r_cnt + 4'd1) : 4'd1;
  assign w_accept  = w_scan_end && w_cnt_nxt == DEB && w_res != r_stable;
  assign w_event   = w_accept && w_res[4] && w_res[3:0] != POP_KEY;
  assign w_toggle  = w_accept && w_res == {1'b1, POP_KEY};
  assign key_held  = r_stable[4];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_row_s1  <= 4'hF;
      r_row_s2  <= 4'hF;
      r_hits    <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_stable  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      pop       <= 1'b0;
    end else begin
      r_row_s1  <= row;
      r_row_s2  <= r_row_s1;
      key_valid <= w_event;
      for (int c = 0; c < 3; c++) if (w_sample && r_col_idx == 2'(c)) r_hits[c] <= ~r_row_s2;
      if (w_scan_end) begin
        r_cand <= w_res;
        r_cnt  <= w_cnt_nxt;
      end
      if (w_accept) r_stable <= w_res;
      if (w_event) key_code <= w_res[3:0];
      pop <= pop_clear ? 1'b0 : w_toggle ? ~pop : pop;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives an electrical keypad model per scan and checks events against
// a scan-level debounce model (history of the last DEB scan results).
module tb_keypad_scanner;
  localparam int DEB  = 2;
  localparam int SCAN = 16;

  logic       clk = 1'b0, reset_n = 1'b0, pop_clear = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held, pop;
  logic [15:0] pressed = '0;
  int checks = 0, failures = 0, obs_pulses = 0;
  int hist[$];
  int m_stable = -1;
  logic [3:0] m_code = '0;
  logic m_pop = 1'b0, m_pulse = 1'b0;
  logic [7:0] obs_v, exp_v;
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  keypad_scanner #(.CLK_HZ(16), .SCAN_HZ(4), .DEBOUNCE_SCANS(DEB), .POP_KEY(4'hE)) dut (
    .clk(clk), .reset_n(reset_n), .row(row), .col(col), .pop_clear(pop_clear),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .pop(pop));

  always #5 clk = ~clk;

  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  function automatic logic [15:0] kmask(input int code);
    kmask = '0;
    for (int i = 0; i < 16; i++) if (keymap[i] == code) kmask[i] = 1'b1;
  endfunction

  function automatic int scan_result(input logic [15:0] m);
    scan_result = -1;
    if ($countones(m) == 1) for (int i = 0; i < 16; i++) if (m[i]) scan_result = keymap[i];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_stable = -1;
    m_code = '0;
    m_pop = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_scan(input logic [15:0] m, input logic clr);
    int res;
    bit acc;
    res = scan_result(m);
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    acc = (hist.size() == DEB) && (res != m_stable);
    foreach (hist[i]) if (hist[i] != res) acc = 0;
    m_pulse = 1'b0;
    if (acc) begin
      m_stable = res;
      if (res == 14) m_pop = ~m_pop;
      else if (res >= 0) begin
        m_code = 4'(res);
        m_pulse = 1'b1;
      end
    end
    if (clr) m_pop = 1'b0;
    exp_v = {1'b0, m_pulse, m_code, m_stable >= 0, m_pop};
  endtask

  task automatic run_cycles(input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      pop_clear = (i == n - 1) ? clr : 1'b0;
      @(posedge clk);
      #1;
      pop_clear = 1'b0;
      if (key_valid) obs_pulses++;
    end
  endtask

  task automatic step(input logic [15:0] m, input logic clr);
    pressed = m;
    obs_pulses = 0;
    run_cycles(SCAN, clr);
    model_scan(m, clr);
    obs_v = {2'(obs_pulses > 3 ? 3 : obs_pulses), key_code, key_held, pop};
  endtask

  task automatic test_reset();
    logic [3:0] ec;
    reset_n = 1'b0;
    pressed = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if ({col, key_code, key_valid, key_held, pop} !== 11'b1110_0000_000) begin
        failures++;
        $display("FAIL reset_hold: col=%b code=%h valid=%b held=%b pop=%b, expected col=1110 and zeros",
                 col, key_code, key_valid, key_held, pop);
      end
    end
    reset_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 2 * SCAN; k++) begin
      @(posedge clk);
      #1;
      ec = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (col !== ec) begin
        failures++;
        $display("FAIL col_seq cycle %0d: col=%b expected %b", k, col, ec);
      end
    end
    model_scan('0, 1'b0);
    model_scan('0, 1'b0);
  endtask

  task automatic run_seq(input string name, input logic [15:0] seq[$], input logic clrs[$], input int want);
    int total = 0;
    foreach (seq[i]) begin
      step(seq[i], clrs[i]);
      total += obs_pulses;
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL %s scan %0d: got pulses=%0d code=%h held=%b pop=%b, expected pulses=%0d code=%h held=%b pop=%b",
                 name, i, obs_v[7:6], obs_v[5:2], obs_v[1], obs_v[0], exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
    if (want >= 0) begin
      checks++;
      if (total != want) begin
        failures++;
        $display("FAIL %s total_pulses: got %0d expected %0d", name, total, want);
      end
    end
  endtask

  task automatic test_key5();
    logic [15:0] s[$];
    logic c[$];
    repeat (6) begin s.push_back(kmask(5)); c.push_back(1'b0); end
    repeat (3) begin s.push_back('0); c.push_back(1'b0); end
    run_seq("key5", s, c, 1);
  endtask

  task automatic test_bounce();
    logic [15:0] s[$] = '{kmask(7), '0, kmask(7), kmask(7), kmask(7), '0, '0};
    logic c[$] = '{0, 0, 0, 0, 0, 0, 0};
    run_seq("bounce", s, c, 1);
  endtask

  task automatic test_multi();
    logic [15:0] s[$];
    logic c[$];
    repeat (4) begin s.push_back(kmask(1) | kmask(6)); c.push_back(1'b0); end
    repeat (3) begin s.push_back(kmask(1)); c.push_back(1'b0); end
    repeat (2) begin s.push_back('0); c.push_back(1'b0); end
    run_seq("multi", s, c, 1);
  endtask

  task automatic test_pop();
    logic [15:0] e, s[$];
    logic c[$];
    e = kmask(14);
    s = '{e, e, e, '0, '0, e, e, e, '0, '0, e, e, e, '0, '0};
    c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    run_seq("pop", s, c, 0);
  endtask

  task automatic test_reset_mid();
    logic [15:0] s[$];
    logic c[$];
    step(kmask(3), 1'b0);
    obs_pulses = 0;
    run_cycles(8, 1'b0);
    checks++;
    if (obs_pulses != 0) begin
      failures++;
      $display("FAIL reset_mid pre_reset: got %0d pulses expected 0", obs_pulses);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    checks++;
    if ({key_code, key_valid, key_held, pop} !== 7'b0) begin
      failures++;
      $display("FAIL reset_mid outputs: code=%h valid=%b held=%b pop=%b expected zeros", key_code, key_valid, key_held, pop);
    end
    repeat (3) begin s.push_back(kmask(3)); c.push_back(1'b0); end
    repeat (2) begin s.push_back('0); c.push_back(1'b0); end
    run_seq("reset_mid", s, c, 1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] s[$] = '{kmask(2), kmask(2), kmask(2), kmask(9), kmask(9), kmask(9),
                          kmask(10), kmask(10), kmask(11), kmask(11), '0, '0};
    logic c[$] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_seq("back_to_back", s, c, 4);
  endtask

  task automatic test_random();
    logic [15:0] s[$], m;
    logic c[$];
    int a, b;
    for (int g = 0; g < 40; g++) begin
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = 16'(1) << a;
        2: m = kmask(14);
        default: m = (16'(1) << a) | (16'(1) << b);
      endcase
      repeat ($urandom_range(1, 3)) begin
        s.push_back(m);
        c.push_back($urandom_range(0, 5) == 0);
      end
    end
    run_seq("random", s, c, -1);
  endtask

  initial begin
    test_reset();
    test_key5();
    test_bounce();
    test_multi();
    test_pop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
